// File: rtl/sonar_ranger.sv
// HC-SR04 style ultrasonic ranger: periodic TRIGGER pulse, ECHO width timing in clk cycles.
// Optional SONAR_MM_EN adds a registered distance_mm output and delays valid by one cycle.
module sonar_ranger #(
    parameter int unsigned TRIG_CYCLES         = 500,
    parameter int unsigned PERIOD_CYCLES       = 3000000,
    parameter int unsigned ECHO_TIMEOUT_CYCLES = 1900000,
    parameter int unsigned SYNC_STAGES         = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        echo_in,
    output logic        trigger_out,
    output logic [31:0] echo_width,
    output logic        valid,
    output logic        timeout_flag,
    output logic [15:0] meas_count
`ifdef SONAR_MM_EN
    ,
    output logic [15:0] distance_mm
`endif
);

    localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [31:0] TRIG_LAST    = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(ECHO_TIMEOUT_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_MAX  = 32'(ECHO_TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

    state_t        state, state_next;
    logic [SS-1:0] sync;
    logic          echo_s, echo_d, echo_rise;
    logic [31:0]   cnt, cnt_next;
    logic [31:0]   period_cnt;
    logic          period_clear;
    logic          load, load_timeout;
    logic          result_pulse;

    assign echo_s    = sync[SS-1];
    assign echo_rise = echo_s & ~echo_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync   <= '0;
            echo_d <= 1'b0;
        end else begin
            sync   <= {sync[SS-2:0], echo_in};
            echo_d <= echo_s;
        end
    end

    // One shared counter: trigger length in TRIG, elapsed wait in WAIT_RISE, width in MEASURE.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        period_clear = 1'b0;
        load         = 1'b0;
        load_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !echo_s) begin
                    state_next   = TRIG;
                    cnt_next     = '0;
                    period_clear = 1'b1;
                end
            end
            TRIG: begin
                if (cnt == TRIG_LAST) begin
                    state_next = WAIT_RISE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            WAIT_RISE: begin
                if (echo_rise) begin
                    state_next = MEASURE;
                    cnt_next   = 32'd1;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next   = HOLDOFF;
                    load         = 1'b1;
                    load_timeout = 1'b1;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    state_next = HOLDOFF;
                    load       = 1'b1;
                end else if (cnt == TIMEOUT_MAX) begin
                    state_next   = HOLDOFF;
                    load         = 1'b1;
                    load_timeout = 1'b1;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            HOLDOFF: begin
                // Never fire a trigger onto an echo that is still high.
                if (period_cnt == PERIOD_LAST && !echo_s) begin
                    if (enable) begin
                        state_next   = TRIG;
                        cnt_next     = '0;
                        period_clear = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            period_cnt  <= '0;
            trigger_out <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            trigger_out <= (state_next == TRIG);
            if (period_clear)
                period_cnt <= '0;
            else if (period_cnt != PERIOD_LAST)
                period_cnt <= period_cnt + 32'd1;
        end
    end

    // Result word, flag and count move together on one edge so SPI never sees a torn result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_width   <= '0;
            timeout_flag <= 1'b0;
            meas_count   <= '0;
            result_pulse <= 1'b0;
        end else begin
            result_pulse <= load;
            if (load) begin
                echo_width   <= load_timeout ? 32'hFFFF_FFFF : cnt;
                timeout_flag <= load_timeout;
                meas_count   <= meas_count + 16'd1;
            end
        end
    end

`ifdef SONAR_MM_EN
    logic [39:0] mm_product;
    logic        mm_valid;

    assign mm_product = {8'd0, echo_width} * 40'd225;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            distance_mm <= '0;
            mm_valid    <= 1'b0;
        end else begin
            mm_valid <= result_pulse;
            if (result_pulse)
                distance_mm <= timeout_flag ? 16'hFFFF : mm_product[31:16];
        end
    end

    assign valid = mm_valid;
`else
    assign valid = result_pulse;
`endif

endmodule
